// File: rtl/c499_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : c499_key_sequencer
// Description : Serial key-frame loader for the locked c499 datapath. Accepts
//               an 8-bit frame LSB first (5 key bits + 3-bit popcount
//               checksum), verifies it, and drives the registered key bits.
//               Failed frames are counted and can trigger a permanent
//               lockout that only reset clears.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_FAIL    : failed frames that trigger lockout (1..3)
// Configuration macro
//   C499_KEY_LOCKOUT_EN : when defined, the LOCKOUT state is built; when
//                         undefined, locked_out is tied 0 and every failure
//                         returns to IDLE.
// Ports
//   CK          : clock, rising edge
//   RN          : asynchronous active-low reset
//   load_req    : start a key-frame load (sampled in IDLE only)
//   key_sdi     : serial frame data, LSB first
//   key_vld     : key_sdi valid this cycle
//   key_rdy     : bit accepted this cycle (LOAD only)
//   p1..p4      : registered mux-select key bits
//   X_1         : registered XOR key bit
//   key_ok      : applied key passed its checksum
//   key_err     : one-cycle pulse on checksum failure
//   locked_out  : lockout active
//   fail_cnt    : saturating failed-frame count
//   busy        : state is LOAD or CHECK
// ============================================================================
module c499_key_sequencer #(
  parameter int MAX_FAIL = 3
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       load_req,
  input  logic       key_sdi,
  input  logic       key_vld,
  output logic       key_rdy,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic       p4,
  output logic       X_1,
  output logic       key_ok,
  output logic       key_err,
  output logic       locked_out,
  output logic [1:0] fail_cnt,
  output logic       busy
);

  // Reject out-of-range thresholds at elaboration time.
  if ((MAX_FAIL < 1) || (MAX_FAIL > 3)) begin : g_bad_max_fail
    $error("c499_key_sequencer: MAX_FAIL must be in 1..3");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_CHECK   = 2'd2
`ifdef C499_KEY_LOCKOUT_EN
    ,
    ST_LOCKOUT = 2'd3
`endif
  } state_t;

  state_t     r_state;
  logic [7:0] r_frame;
  logic [2:0] r_bit_cnt;

  logic [2:0] w_popcnt;
  logic       w_pass;
  logic [1:0] w_fail_nxt;

  // Checksum covers the five key bits; 0..5 fits in 3 bits.
  always_comb begin
    w_popcnt = 3'(r_frame[0]) + 3'(r_frame[1]) + 3'(r_frame[2])
             + 3'(r_frame[3]) + 3'(r_frame[4]);
    w_pass   = (r_frame[7:5] == w_popcnt);
    w_fail_nxt = (fail_cnt == 2'd3) ? 2'd3 : (fail_cnt + 2'd1);
  end

`ifdef C499_KEY_LOCKOUT_EN
  localparam logic [1:0] C_MAX_FAIL = 2'(MAX_FAIL);
  logic w_lock_hit;
  assign w_lock_hit = (w_fail_nxt == C_MAX_FAIL);
`else
  assign locked_out = 1'b0;
`endif

  // Handshake and status are pure decodes of the state register.
  assign key_rdy = (r_state == ST_LOAD);
  assign busy    = (r_state == ST_LOAD) || (r_state == ST_CHECK);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state    <= ST_IDLE;
      r_frame    <= 8'd0;
      r_bit_cnt  <= 3'd0;
      p1         <= 1'b0;
      p2         <= 1'b0;
      p3         <= 1'b0;
      p4         <= 1'b0;
      X_1        <= 1'b0;
      key_ok     <= 1'b0;
      key_err    <= 1'b0;
      fail_cnt   <= 2'd0;
`ifdef C499_KEY_LOCKOUT_EN
      locked_out <= 1'b0;
`endif
    end else begin
      key_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_req) begin
            // A new load always starts from an empty frame.
            r_state   <= ST_LOAD;
            r_frame   <= 8'd0;
            r_bit_cnt <= 3'd0;
            key_ok    <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (key_vld) begin
            // LSB first: the first bit received ends up in r_frame[0].
            r_frame   <= {key_sdi, r_frame[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          r_state <= ST_IDLE;
          if (w_pass) begin
            p1       <= r_frame[0];
            p2       <= r_frame[1];
            p3       <= r_frame[2];
            p4       <= r_frame[3];
            X_1      <= r_frame[4];
            key_ok   <= 1'b1;
            fail_cnt <= 2'd0;
          end else begin
            p1       <= 1'b0;
            p2       <= 1'b0;
            p3       <= 1'b0;
            p4       <= 1'b0;
            X_1      <= 1'b0;
            key_ok   <= 1'b0;
            key_err  <= 1'b1;
            fail_cnt <= w_fail_nxt;
`ifdef C499_KEY_LOCKOUT_EN
            if (w_lock_hit) begin
              r_state    <= ST_LOCKOUT;
              locked_out <= 1'b1;
            end
`endif
          end
        end

`ifdef C499_KEY_LOCKOUT_EN
        ST_LOCKOUT: begin
          // Terminal until reset; key bits forced inactive.
          p1     <= 1'b0;
          p2     <= 1'b0;
          p3     <= 1'b0;
          p4     <= 1'b0;
          X_1    <= 1'b0;
          key_ok <= 1'b0;
        end
`endif

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c499_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_c499_key_sequencer
// Description : Self-checking bench for c499_key_sequencer. Frame results are
//               predicted by a reference model when a frame is driven, queued,
//               and compared by a monitor the cycle after CHECK.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c499_key_sequencer;

  localparam int MAX_FAIL = 3;

  logic       CK;
  logic       RN;
  logic       load_req;
  logic       key_sdi;
  logic       key_vld;
  logic       key_rdy;
  logic       p1, p2, p3, p4, X_1;
  logic       key_ok;
  logic       key_err;
  logic       locked_out;
  logic [1:0] fail_cnt;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0] key;
    logic       ok;
    logic       err;
    logic [1:0] fcnt;
    logic       lock;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_fail   = 0;
  bit m_locked = 1'b0;

  c499_key_sequencer #(.MAX_FAIL(MAX_FAIL)) dut (
    .CK        (CK),
    .RN        (RN),
    .load_req  (load_req),
    .key_sdi   (key_sdi),
    .key_vld   (key_vld),
    .key_rdy   (key_rdy),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .X_1       (X_1),
    .key_ok    (key_ok),
    .key_err   (key_err),
    .locked_out(locked_out),
    .fail_cnt  (fail_cnt),
    .busy      (busy)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Scoreboard monitor: outputs are compared the cycle after CHECK, and
  // key_err must fall again one cycle later.
  bit mon_was_check = 1'b0;
  bit mon_err_chk   = 1'b0;
  always begin
    exp_t e;
    @(posedge CK);
    #1;
    if (mon_err_chk) begin
      checks++;
      if (key_err !== 1'b0) begin
        failures++;
        $display("FAIL key_err_width actual=%b expected=0", key_err);
      end
    end
    mon_err_chk = 1'b0;
    if (mon_was_check) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_result actual=result expected=none");
      end else begin
        e = sb.pop_front();
        if ({X_1, p4, p3, p2, p1} !== e.key || key_ok !== e.ok ||
            key_err !== e.err || fail_cnt !== e.fcnt || locked_out !== e.lock) begin
          failures++;
          $display("FAIL sb_result actual key=%b ok=%b err=%b fcnt=%0d lock=%b expected key=%b ok=%b err=%b fcnt=%0d lock=%b",
                   {X_1, p4, p3, p2, p1}, key_ok, key_err, fail_cnt, locked_out,
                   e.key, e.ok, e.err, e.fcnt, e.lock);
        end
      end
      mon_err_chk = 1'b1;
    end
    mon_was_check = (RN === 1'b1) && (busy === 1'b1) && (key_rdy === 1'b0);
  end

  // Drives one frame starting in IDLE and queues the predicted result.
  // Bit i of f is sent i-th. With gaps, every bit is preceded by a key_vld=0
  // cycle; mid_req raises load_req on one of those gap cycles.
  task automatic drive_frame(input logic [7:0] f, input bit gaps, input bit mid_req);
    exp_t e;
    int   pc;
    pc = 0;
    for (int i = 0; i < 5; i++) pc += int'(f[i]);
    if (int'(f[7:5]) == pc) begin
      e.key  = f[4:0];
      e.ok   = 1'b1;
      e.err  = 1'b0;
      m_fail = 0;
    end else begin
      e.key = 5'd0;
      e.ok  = 1'b0;
      e.err = 1'b1;
      if (m_fail < 3) m_fail++;
`ifdef C499_KEY_LOCKOUT_EN
      if (m_fail == MAX_FAIL) m_locked = 1'b1;
`endif
    end
    e.fcnt = 2'(m_fail);
    e.lock = m_locked;
    sb.push_back(e);

    load_req = 1'b1;
    key_vld  = 1'b0;
    tick();
    load_req = 1'b0;
    checks++;
    if (key_ok !== 1'b0 || key_rdy !== 1'b1) begin
      failures++;
      $display("FAIL load_entry actual ok=%b rdy=%b expected ok=0 rdy=1", key_ok, key_rdy);
    end
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        key_vld  = 1'b0;
        key_sdi  = ~f[i];
        load_req = mid_req && (i == 3);
        tick();
        load_req = 1'b0;
      end
      key_vld = 1'b1;
      key_sdi = f[i];
      tick();
    end
    key_vld = 1'b0;
    checks++;
    if (busy !== 1'b1 || key_rdy !== 1'b0) begin
      failures++;
      $display("FAIL check_state actual busy=%b rdy=%b expected busy=1 rdy=0", busy, key_rdy);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || key_rdy !== 1'b0) begin
      failures++;
      $display("FAIL return_idle actual busy=%b rdy=%b expected busy=0 rdy=0", busy, key_rdy);
    end
  endtask

  task automatic test_reset();
    RN       = 1'b1;
    load_req = 1'b0;
    key_sdi  = 1'b0;
    key_vld  = 1'b0;
    #2;
    RN = 1'b0;
    #1;
    checks++;
    if ({key_rdy, busy, p1, p2, p3, p4, X_1, key_ok, key_err, locked_out, fail_cnt} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b expected=0",
               {key_rdy, busy, p1, p2, p3, p4, X_1, key_ok, key_err, locked_out, fail_cnt});
    end
    // key_vld outside LOAD must not start anything.
    key_vld = 1'b1;
    tick();
    tick();
    RN = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || key_rdy !== 1'b0 || fail_cnt !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_idle actual busy=%b rdy=%b fcnt=%0d expected 0 0 0", busy, key_rdy, fail_cnt);
    end
    key_vld = 1'b0;
  endtask

  task automatic test_good_frame();
    drive_frame(8'h6D, 1'b0, 1'b0);
    checks++;
    if ({X_1, p4, p3, p2, p1} !== 5'b01101 || key_ok !== 1'b1 || fail_cnt !== 2'd0) begin
      failures++;
      $display("FAIL good_frame actual key=%b ok=%b fcnt=%0d expected key=01101 ok=1 fcnt=0",
               {X_1, p4, p3, p2, p1}, key_ok, fail_cnt);
    end
  endtask

  task automatic test_bad_frame();
    drive_frame(8'h0D, 1'b0, 1'b0);
    checks++;
    if ({X_1, p4, p3, p2, p1} !== 5'b00000 || fail_cnt !== 2'd1 || key_ok !== 1'b0) begin
      failures++;
      $display("FAIL bad_frame actual key=%b ok=%b fcnt=%0d expected key=00000 ok=0 fcnt=1",
               {X_1, p4, p3, p2, p1}, key_ok, fail_cnt);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] pats [4];
    pats = '{8'hBF, 8'h30, 8'h6C, 8'h00};
    foreach (pats[k]) drive_frame(pats[k], 1'b0, 1'b0);
    checks++;
    if (key_ok !== 1'b1 || fail_cnt !== 2'd0) begin
      failures++;
      $display("FAIL patterns_final actual ok=%b fcnt=%0d expected ok=1 fcnt=0", key_ok, fail_cnt);
    end
  endtask

  task automatic test_gaps();
    drive_frame(8'h6D, 1'b1, 1'b1);
    checks++;
    if ({X_1, p4, p3, p2, p1} !== 5'b01101 || key_ok !== 1'b1) begin
      failures++;
      $display("FAIL gaps_frame actual key=%b ok=%b expected key=01101 ok=1",
               {X_1, p4, p3, p2, p1}, key_ok);
    end
  endtask

`ifdef C499_KEY_LOCKOUT_EN
  task automatic test_lockout();
    for (int n = 0; n < 3; n++) drive_frame(8'h0D, 1'b0, 1'b0);
    checks++;
    if (locked_out !== 1'b1) begin
      failures++;
      $display("FAIL lockout_entry actual=%b expected=1", locked_out);
    end
    // A good frame in lockout must be ignored entirely.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_vld = 1'b1;
      key_sdi = i[0];
      tick();
      checks++;
      if (key_rdy !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL lockout_ignore actual rdy=%b busy=%b expected 0 0", key_rdy, busy);
      end
    end
    key_vld = 1'b0;
    checks++;
    if ({X_1, p4, p3, p2, p1} !== 5'd0 || key_ok !== 1'b0 || locked_out !== 1'b1) begin
      failures++;
      $display("FAIL lockout_hold actual key=%b ok=%b lock=%b expected 00000 0 1",
               {X_1, p4, p3, p2, p1}, key_ok, locked_out);
    end
    #2;
    RN = 1'b0;
    #1;
    checks++;
    if (locked_out !== 1'b0 || fail_cnt !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL lockout_reset actual lock=%b fcnt=%0d busy=%b expected 0 0 0", locked_out, fail_cnt, busy);
    end
    tick();
    RN       = 1'b1;
    m_fail   = 0;
    m_locked = 1'b0;
    tick();
  endtask
`else
  task automatic test_fail_saturation();
    for (int n = 0; n < 4; n++) drive_frame(8'h0D, 1'b0, 1'b0);
    checks++;
    if (locked_out !== 1'b0 || fail_cnt !== 2'd3) begin
      failures++;
      $display("FAIL sat_count actual lock=%b fcnt=%0d expected lock=0 fcnt=3", locked_out, fail_cnt);
    end
    drive_frame(8'h6D, 1'b0, 1'b0);
    checks++;
    if (fail_cnt !== 2'd0 || key_ok !== 1'b1) begin
      failures++;
      $display("FAIL sat_recover actual fcnt=%0d ok=%b expected fcnt=0 ok=1", fail_cnt, key_ok);
    end
  endtask
`endif

  task automatic test_reset_midload();
    logic [7:0] f;
    drive_frame(8'h6D, 1'b0, 1'b0);
    f = 8'hBF;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_vld = 1'b1;
      key_sdi = f[i];
      tick();
    end
    key_vld = 1'b0;
    #2;
    RN = 1'b0;
    #1;
    checks++;
    if ({key_rdy, busy, p1, p2, p3, p4, X_1, key_ok, key_err, locked_out, fail_cnt} !== 12'd0) begin
      failures++;
      $display("FAIL midload_reset actual=%b expected=0",
               {key_rdy, busy, p1, p2, p3, p4, X_1, key_ok, key_err, locked_out, fail_cnt});
    end
    tick();
    RN       = 1'b1;
    m_fail   = 0;
    m_locked = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || {X_1, p4, p3, p2, p1} !== 5'd0) begin
      failures++;
      $display("FAIL midload_no_apply actual busy=%b key=%b expected 0 00000", busy, {X_1, p4, p3, p2, p1});
    end
    drive_frame(8'hBF, 1'b0, 1'b0);
    checks++;
    if ({X_1, p4, p3, p2, p1} !== 5'b11111 || key_ok !== 1'b1) begin
      failures++;
      $display("FAIL midload_reload actual key=%b ok=%b expected 11111 1", {X_1, p4, p3, p2, p1}, key_ok);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_patterns();
    test_gaps();
`ifdef C499_KEY_LOCKOUT_EN
    test_lockout();
`else
    test_fail_saturation();
`endif
    test_reset_midload();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
